// File: rtl/coincidence_serializer_if.sv
// Output stream of the coincidence serializer toward the readout/transmit link.
// The serializer drives beats through the master modport, and the link consumer
// uses the slave modport and returns out_ready.
interface coincidence_serializer_if #(
  parameter int OUT_WIDTH = 64
);
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_sop;
  logic                 out_eop;

  modport master (
    output out_data,
    output out_valid,
    output out_sop,
    output out_eop,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_sop,
    input  out_eop,
    output out_ready
  );
endinterface

// File: rtl/coincidence_serializer.sv
// Coincidence serializer.
// Reads one wide coincidence frame from the non-showahead coincidence buffer FIFO.
// It then sends that frame on a valid/ready stream of OUT_WIDTH-bit beats:
// one header beat (magic, sequence number, beat count) followed by NUM_BEATS data
// slices, least significant slice first.
// Every output is driven from a flop. out_ready only reaches flop inputs.
// OUT_WIDTH must divide COINCIDENCE_BUFFER_WIDTH and must be at least 64,
// because the header occupies the low 64 bits of a beat.
// FRAME_CNT_RESET is the value frame_cnt takes on reset. It stays 0 in
// normal use and only exists so the 16-bit sequence wrap can be reached
// quickly.
module coincidence_serializer #(
  parameter int          COINCIDENCE_BUFFER_WIDTH = 1024,
  parameter int          OUT_WIDTH                = 64,
  parameter logic [15:0] FRAME_MAGIC              = 16'hC01C,
  parameter logic [15:0] FRAME_CNT_RESET          = 16'h0000
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                buffer_empty,
  output logic                                odata_req,
  input  logic [COINCIDENCE_BUFFER_WIDTH-1:0] odata,
  coincidence_serializer_if.master            link,
  output logic                                busy,
  output logic [15:0]                         frame_cnt
);

  localparam int NUM_BEATS = COINCIDENCE_BUFFER_WIDTH / OUT_WIDTH;
  localparam int IDX_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX      = IDX_W'(NUM_BEATS - 1);
  localparam logic [15:0]      NUM_BEATS_TAG = 16'(NUM_BEATS);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_LOAD = 3'd2,
    ST_HDR  = 3'd3,
    ST_DATA = 3'd4
  } state_t;

  state_t                              state_r;
  state_t                              state_nxt_s;
  logic [COINCIDENCE_BUFFER_WIDTH-1:0] shift_r;
  logic [COINCIDENCE_BUFFER_WIDTH-1:0] shift_nxt_s;
  logic [IDX_W-1:0]                    beat_idx_r;
  logic [IDX_W-1:0]                    beat_idx_nxt_s;
  logic [OUT_WIDTH-1:0]                out_data_r;
  logic [OUT_WIDTH-1:0]                out_data_nxt_s;
  logic                                out_valid_r;
  logic                                out_valid_nxt_s;
  logic                                out_sop_r;
  logic                                out_sop_nxt_s;
  logic                                out_eop_r;
  logic                                out_eop_nxt_s;
  logic                                odata_req_r;
  logic                                odata_req_nxt_s;
  logic                                busy_r;
  logic                                busy_nxt_s;
  logic [15:0]                         frame_cnt_r;
  logic [15:0]                         frame_cnt_nxt_s;
  logic                                handshake_s;
  logic                                last_beat_s;

  // Build the header beat: magic, sequence number, beat count, and zeros elsewhere.
  function automatic logic [OUT_WIDTH-1:0] header_beat(input logic [15:0] seq);
    logic [OUT_WIDTH-1:0] h;
    h        = {OUT_WIDTH{1'b0}};
    h[63:48] = FRAME_MAGIC;
    h[47:32] = seq;
    h[31:16] = NUM_BEATS_TAG;
    return h;
  endfunction

  assign handshake_s = out_valid_r & link.out_ready;
  assign last_beat_s = (beat_idx_r == LAST_IDX);

  assign odata_req      = odata_req_r;
  assign busy           = busy_r;
  assign frame_cnt      = frame_cnt_r;
  assign link.out_data  = out_data_r;
  assign link.out_valid = out_valid_r;
  assign link.out_sop   = out_sop_r;
  assign link.out_eop   = out_eop_r;

  // State register. Reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic. buffer_empty is only looked at while IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!buffer_empty) begin
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ:  state_nxt_s = ST_LOAD;
      ST_LOAD: state_nxt_s = ST_HDR;
      ST_HDR: begin
        if (handshake_s) begin
          state_nxt_s = ST_DATA;
        end else begin
          state_nxt_s = ST_HDR;
        end
      end
      ST_DATA: begin
        if (handshake_s && last_beat_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath. Beats are held while stalled.
  always_comb begin
    odata_req_nxt_s = 1'b0;
    out_valid_nxt_s = out_valid_r;
    out_sop_nxt_s   = out_sop_r;
    out_eop_nxt_s   = out_eop_r;
    out_data_nxt_s  = out_data_r;
    shift_nxt_s     = shift_r;
    beat_idx_nxt_s  = beat_idx_r;
    frame_cnt_nxt_s = frame_cnt_r;
    busy_nxt_s      = (state_nxt_s != ST_IDLE);
    case (state_r)
      ST_IDLE: begin
        // The read request comes up together with the move to REQ.
        if (!buffer_empty) begin
          odata_req_nxt_s = 1'b1;
        end else begin
          odata_req_nxt_s = 1'b0;
        end
      end
      ST_REQ: begin
        // FIFO data becomes valid during LOAD; nothing to drive yet.
        odata_req_nxt_s = 1'b0;
      end
      ST_LOAD: begin
        shift_nxt_s     = odata;
        out_data_nxt_s  = header_beat(frame_cnt_r);
        out_valid_nxt_s = 1'b1;
        out_sop_nxt_s   = 1'b1;
        out_eop_nxt_s   = 1'b0;
      end
      ST_HDR: begin
        if (handshake_s) begin
          out_data_nxt_s = shift_r[OUT_WIDTH-1:0];
          shift_nxt_s    = shift_r >> OUT_WIDTH;
          beat_idx_nxt_s = {IDX_W{1'b0}};
          out_sop_nxt_s  = 1'b0;
          out_eop_nxt_s  = (LAST_IDX == {IDX_W{1'b0}});
        end else begin
          out_valid_nxt_s = 1'b1;
        end
      end
      ST_DATA: begin
        if (handshake_s) begin
          if (last_beat_s) begin
            out_valid_nxt_s = 1'b0;
            out_sop_nxt_s   = 1'b0;
            out_eop_nxt_s   = 1'b0;
            out_data_nxt_s  = {OUT_WIDTH{1'b0}};
            frame_cnt_nxt_s = frame_cnt_r + 16'd1;
          end else begin
            out_data_nxt_s = shift_r[OUT_WIDTH-1:0];
            shift_nxt_s    = shift_r >> OUT_WIDTH;
            beat_idx_nxt_s = beat_idx_r + IDX_W'(1);
            out_eop_nxt_s  = ((beat_idx_r + IDX_W'(1)) == LAST_IDX);
          end
        end else begin
          out_valid_nxt_s = 1'b1;
        end
      end
      default: begin
        odata_req_nxt_s = 1'b0;
        out_valid_nxt_s = 1'b0;
        out_sop_nxt_s   = 1'b0;
        out_eop_nxt_s   = 1'b0;
      end
    endcase
  end

  // Output and datapath registers. All are cleared on reset; frame_cnt restarts.
  always_ff @(posedge clk) begin
    if (rst) begin
      odata_req_r <= 1'b0;
      out_valid_r <= 1'b0;
      out_sop_r   <= 1'b0;
      out_eop_r   <= 1'b0;
      out_data_r  <= {OUT_WIDTH{1'b0}};
      shift_r     <= {COINCIDENCE_BUFFER_WIDTH{1'b0}};
      beat_idx_r  <= {IDX_W{1'b0}};
      busy_r      <= 1'b0;
      frame_cnt_r <= FRAME_CNT_RESET;
    end else begin
      odata_req_r <= odata_req_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      out_sop_r   <= out_sop_nxt_s;
      out_eop_r   <= out_eop_nxt_s;
      out_data_r  <= out_data_nxt_s;
      shift_r     <= shift_nxt_s;
      beat_idx_r  <= beat_idx_nxt_s;
      busy_r      <= busy_nxt_s;
      frame_cnt_r <= frame_cnt_nxt_s;
    end
  end

endmodule

// File: tb/tb_coincidence_serializer.sv
// Self-checking bench for coincidence_serializer.
// A queue models the FIFO, and a scoreboard of expected beats is filled as
// frames are queued. A table of scenarios is applied in a loop. Hand-written
// sequences cover mid-frame reset and the 16-bit sequence wrap, which uses a
// second instance whose frame counter resets to 0xFFFF.
module tb_coincidence_serializer;
  localparam int CBW = 1024;
  localparam int OW  = 64;
  localparam int NB  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           buffer_empty;
  logic           odata_req;
  logic [CBW-1:0] odata;
  logic           busy;
  logic [15:0]    frame_cnt;
  coincidence_serializer_if #(.OUT_WIDTH(OW)) link();

  coincidence_serializer #(.COINCIDENCE_BUFFER_WIDTH(CBW), .OUT_WIDTH(OW)) dut (
    .clk(clk), .rst(rst), .buffer_empty(buffer_empty), .odata_req(odata_req),
    .odata(odata), .link(link), .busy(busy), .frame_cnt(frame_cnt)
  );

  logic           w_rst;
  logic           w_empty;
  logic           w_req;
  logic [CBW-1:0] w_odata;
  logic           w_busy;
  logic [15:0]    w_cnt;
  coincidence_serializer_if #(.OUT_WIDTH(OW)) w_link();

  coincidence_serializer #(.COINCIDENCE_BUFFER_WIDTH(CBW), .OUT_WIDTH(OW),
                           .FRAME_CNT_RESET(16'hFFFF)) dut_wrap (
    .clk(clk), .rst(w_rst), .buffer_empty(w_empty), .odata_req(w_req),
    .odata(w_odata), .link(w_link), .busy(w_busy), .frame_cnt(w_cnt)
  );

  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
  } beat_t;

  typedef struct {
    bit          do_reset;
    int          nframes;
    bit          rand_ready;
    logic [63:0] base;
    int          exp_reqs;
    logic [15:0] exp_cnt;
    bit          chk_period;
  } vec_t;

  beat_t          sb[$];
  logic [CBW-1:0] fifo_q[$];
  int             req_cycles[$];
  int             checks = 0;
  int             errors = 0;
  int             cycle = 0;
  int             req_cnt = 0;
  int             hs_total = 0;
  int             first_sop_cycle = -1;
  logic [15:0]    exp_seq = 16'h0000;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic logic [CBW-1:0] make_frame(input logic [63:0] base);
    logic [CBW-1:0] f;
    for (int k = 0; k < NB; k++) f[k*OW +: OW] = base + 64'(k);
    return f;
  endfunction

  // Queue a frame in the FIFO model and append its expected beats.
  task automatic push_frame(input logic [CBW-1:0] f);
    beat_t b;
    fifo_q.push_back(f);
    buffer_empty = 1'b0;
    b = '{data: {16'hC01C, exp_seq, 16'h0010, 16'h0000}, sop: 1'b1, eop: 1'b0};
    sb.push_back(b);
    for (int k = 0; k < NB; k++) begin
      b = '{data: f[k*OW +: OW], sop: 1'b0, eop: (k == NB - 1)};
      sb.push_back(b);
    end
    exp_seq = exp_seq + 16'd1;
  endtask

  // After a reset, expectations restart at sequence 0 for whatever is still queued.
  task automatic rebuild_sb();
    logic [CBW-1:0] pend[$];
    pend = fifo_q;
    fifo_q.delete();
    sb.delete();
    exp_seq = 16'h0000;
    foreach (pend[i]) push_frame(pend[i]);
    buffer_empty = (fifo_q.size() == 0);
  endtask

  // Advance one clock. Serve FIFO reads, and score beats and stall stability.
  task automatic tick();
    logic  req_now;
    logic  hs;
    logic  stall;
    beat_t cur;
    req_now = odata_req;
    hs      = link.out_valid && link.out_ready && !rst;
    stall   = link.out_valid && !link.out_ready && !rst;
    cur     = '{data: link.out_data, sop: link.out_sop, eop: link.out_eop};
    if (req_now) req_cycles.push_back(cycle);
    if (link.out_valid && link.out_sop && first_sop_cycle < 0) first_sop_cycle = cycle;
    @(posedge clk);
    #1;
    cycle++;
    if (req_now) begin
      req_cnt++;
      if (fifo_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL fifo_underflow: read request with empty FIFO (cycle %0d)", cycle);
      end else begin
        odata = fifo_q.pop_front();
      end
      buffer_empty = (fifo_q.size() == 0);
    end
    if (hs) begin
      hs_total++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got %0h expected none (cycle %0d)", cur, cycle);
      end else begin
        chk("beat", 96'(cur), 96'(sb.pop_front()));
      end
    end
    if (stall) begin
      chk("stall_hold", {link.out_valid, link.out_data, link.out_sop, link.out_eop}, {1'b1, cur});
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
    sb.delete();
    exp_seq = 16'h0000;
  endtask

  task automatic drain(input bit rand_ready);
    for (int c = 0; c < 800; c++) begin
      if (sb.size() == 0 && fifo_q.size() == 0 && !busy) break;
      tick();
      link.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    link.out_ready = 1'b1;
    tick();
    tick();
    chk("drained", {sb.size() == 0, fifo_q.size() == 0, busy, link.out_valid}, 96'b1100);
  endtask

  vec_t tv[4];
  int   push_cycle;
  int   wbeats;
  bit   wdone;
  bit   wreq_seen;

  initial begin
    tv[0] = '{do_reset: 1'b1, nframes: 1, rand_ready: 1'b0, base: 64'h1000_0000_0000_0000,
              exp_reqs: 1, exp_cnt: 16'd1, chk_period: 1'b0};
    tv[1] = '{do_reset: 1'b0, nframes: 1, rand_ready: 1'b1, base: 64'h1000_0000_0000_0000,
              exp_reqs: 1, exp_cnt: 16'd2, chk_period: 1'b0};
    tv[2] = '{do_reset: 1'b1, nframes: 3, rand_ready: 1'b0, base: 64'h2000_0000_0000_0000,
              exp_reqs: 3, exp_cnt: 16'd3, chk_period: 1'b1};
    tv[3] = '{do_reset: 1'b0, nframes: 2, rand_ready: 1'b1, base: 64'h3000_0000_0000_0000,
              exp_reqs: 2, exp_cnt: 16'd5, chk_period: 1'b0};

    rst = 1'b1;
    buffer_empty = 1'b1;
    odata = {CBW{1'b0}};
    link.out_ready = 1'b0;
    w_rst = 1'b1;
    w_empty = 1'b1;
    w_odata = {CBW{1'b0}};
    w_link.out_ready = 1'b1;

    // Reset for three cycles, then idle with an empty FIFO and ready asserted.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_outputs", {odata_req, link.out_valid, link.out_sop, link.out_eop, busy,
                            frame_cnt, link.out_data}, 96'd0);
    end
    rst = 1'b0;
    link.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_outputs", {odata_req, link.out_valid, link.out_sop, link.out_eop, busy,
                           frame_cnt, link.out_data}, 96'd0);
    end
    chk("idle_no_req", 96'(req_cnt), 96'd0);

    // Table-driven scenarios.
    for (int v = 0; v < 4; v++) begin
      if (tv[v].do_reset) do_reset(2);
      req_cnt = 0;
      req_cycles.delete();
      first_sop_cycle = -1;
      link.out_ready = tv[v].rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      push_cycle = cycle;
      for (int f = 0; f < tv[v].nframes; f++) begin
        push_frame(make_frame(tv[v].base + (64'(f) << 32)));
      end
      drain(tv[v].rand_ready);
      chk("req_count", 96'(req_cnt), 96'(tv[v].exp_reqs));
      chk("frame_cnt", 96'(frame_cnt), 96'(tv[v].exp_cnt));
      chk("req_latency", 96'(req_cycles.size() > 0 ? req_cycles[0] - push_cycle : -1), 96'd1);
      chk("hdr_latency", 96'(first_sop_cycle - push_cycle), 96'd3);
      if (tv[v].chk_period) begin
        for (int i = 1; i < req_cycles.size(); i++) begin
          chk("req_period", 96'(req_cycles[i] - req_cycles[i-1]), 96'd20);
        end
      end
    end

    // Reset after data beat 5 of the first of two frames.
    do_reset(2);
    req_cnt = 0;
    hs_total = 0;
    link.out_ready = 1'b1;
    push_frame(make_frame(64'h6000_0000_0000_0000));
    push_frame(make_frame(64'h7000_0000_0000_0000));
    for (int c = 0; c < 100; c++) begin
      if (hs_total >= 7) break;
      tick();
    end
    chk("reached_beat5", 96'(hs_total), 96'd7);
    rst = 1'b1;
    tick();
    chk("midreset_state", {link.out_valid, busy, frame_cnt}, 96'd0);
    rst = 1'b0;
    rebuild_sb();
    drain(1'b0);
    chk("midreset_frame_cnt", 96'(frame_cnt), 96'd1);
    chk("midreset_reqs", 96'(req_cnt), 96'd2);

    // Sequence wrap on the instance whose counter starts at 0xFFFF.
    tick();
    w_rst = 1'b0;
    chk("wrap_start", 96'(w_cnt), 96'hFFFF);
    w_odata = make_frame(64'h5000_0000_0000_0000);
    w_empty = 1'b0;
    wbeats = 0;
    wdone = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (wdone) break;
      wreq_seen = w_req;
      if (w_link.out_valid) begin
        if (w_link.out_sop) begin
          chk("wrap_header", 96'(w_link.out_data), 96'h0000_0000_C01C_FFFF_0010_0000);
        end else begin
          chk("wrap_beat", {w_link.out_eop, w_link.out_data},
              {wbeats == NB - 1, 64'h5000_0000_0000_0000 + 64'(wbeats)});
          wbeats++;
          if (w_link.out_eop) wdone = 1'b1;
        end
      end
      tick();
      if (wreq_seen) w_empty = 1'b1;
    end
    chk("wrap_beats", 96'(wbeats), 96'd16);
    tick();
    chk("wrap_cnt", {w_busy, w_link.out_valid, w_cnt}, 96'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
